// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic       memReady;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic [3:0] state;
   logic       illegalOp;

   modport master (
      input  opcode, memReady,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegalOp
   );

   modport slave (
      output opcode, memReady,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, state, illegalOp
   );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (fetch/decode/exec/mem/wb).
// Outputs decode the registered state; only FETCH's IRWrite/PCWrite follow memReady.
module mips_multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_J     = 6'h02
) (
   input  logic                      clk,
   input  logic                      reset,
   mips_multicycle_control_if.master ctrl
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RTWB   = 4'd7,
      BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_out_t;

   state_t    state_q, state_d;
   logic      is_lw_q, is_lw_d;
   logic      illegal_d;
   ctrl_out_t out_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         is_lw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         is_lw_q <= is_lw_d;
      end
   end

   // lw/sw choice is latched in DECODE so MEMADR never looks at the IR again.
   always_comb begin
      state_d   = FETCH;
      is_lw_d   = is_lw_q;
      illegal_d = 1'b0;
      case (state_q)
         FETCH:  state_d = ctrl.memReady ? DECODE : FETCH;
         DECODE: begin
            is_lw_d = (ctrl.opcode == OP_LW);
            case (ctrl.opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXEC;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default:      illegal_d = 1'b1;
            endcase
         end
         MEMADR: state_d = is_lw_q ? MEMRD : MEMWR;
         MEMRD:  state_d = ctrl.memReady ? MEMWB : MEMRD;
         MEMWR:  state_d = ctrl.memReady ? FETCH : MEMWR;
         EXEC:   state_d = RTWB;
         ADDIEX: state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      out_d = '0;
      case (state_q)
         FETCH: begin
            out_d.mem_read  = 1'b1;
            out_d.alu_src_b = 2'b01;
            out_d.ir_write  = ctrl.memReady;
            out_d.pc_write  = ctrl.memReady;
         end
         DECODE: begin
            out_d.alu_src_b  = 2'b11;
            out_d.illegal_op = illegal_d;
         end
         MEMADR, ADDIEX: begin
            out_d.alu_src_a = 1'b1;
            out_d.alu_src_b = 2'b10;
         end
         MEMRD: begin
            out_d.mem_read = 1'b1;
            out_d.iord     = 1'b1;
         end
         MEMWB: begin
            out_d.reg_write  = 1'b1;
            out_d.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            out_d.mem_write = 1'b1;
            out_d.iord      = 1'b1;
         end
         EXEC: begin
            out_d.alu_src_a = 1'b1;
            out_d.alu_op    = 2'b10;
         end
         RTWB: begin
            out_d.reg_write = 1'b1;
            out_d.reg_dst   = 1'b1;
         end
         BRANCH: begin
            out_d.alu_src_a     = 1'b1;
            out_d.alu_op        = 2'b01;
            out_d.pc_write_cond = 1'b1;
            out_d.pc_source     = 2'b01;
         end
         ADDIWB:  out_d.reg_write = 1'b1;
         JUMP: begin
            out_d.pc_write  = 1'b1;
            out_d.pc_source = 2'b10;
         end
         default: out_d = '0;
      endcase
      if (reset) out_d = '0;
   end

   assign ctrl.PCWrite     = out_d.pc_write;
   assign ctrl.PCWriteCond = out_d.pc_write_cond;
   assign ctrl.IorD        = out_d.iord;
   assign ctrl.MemRead     = out_d.mem_read;
   assign ctrl.MemWrite    = out_d.mem_write;
   assign ctrl.IRWrite     = out_d.ir_write;
   assign ctrl.MemtoReg    = out_d.mem_to_reg;
   assign ctrl.RegDst      = out_d.reg_dst;
   assign ctrl.RegWrite    = out_d.reg_write;
   assign ctrl.ALUSrcA     = out_d.alu_src_a;
   assign ctrl.ALUSrcB     = out_d.alu_src_b;
   assign ctrl.ALUOp       = out_d.alu_op;
   assign ctrl.PCSource    = out_d.pc_source;
   assign ctrl.illegalOp   = out_d.illegal_op;
   assign ctrl.state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multi-cycle MIPS control FSM: drives at negedge, checks #1 later.
module tb_mips_multicycle_control;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   mips_multicycle_control_if bus ();

   mips_multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus.master)
   );

   function automatic logic [20:0] outs();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
              bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
              bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.state, bus.illegalOp};
   endfunction

   task automatic drive(input logic [5:0] op, input logic mr);
      bus.opcode   = op;
      bus.memReady = mr;
      #1;
   endtask

   task automatic test_reset;
      drive(6'h23, 1'b1);
      @(negedge clk);
      drive(6'h23, 1'b1);
      total++;
      if (outs() !== 21'd0) begin
         bad++; $display("FAIL reset_outs got=%h exp=0", outs());
      end
      @(negedge clk);
      reset = 1'b0;
      drive(6'h00, 1'b0);
      total++;
      if (bus.state !== 4'd0 || bus.MemRead !== 1'b1) begin
         bad++; $display("FAIL reset_release state=%0d MemRead=%b exp 0/1", bus.state, bus.MemRead);
      end
      total++;
      if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0 || bus.ALUSrcB !== 2'b01) begin
         bad++; $display("FAIL fetch_idle IRWrite=%b PCWrite=%b ALUSrcB=%b exp 0/0/01",
                         bus.IRWrite, bus.PCWrite, bus.ALUSrcB);
      end
   endtask

   task automatic test_lw;
      int st[6];
      logic [5:0] op[6];
      st = '{0, 1, 2, 3, 4, 0};
      op = '{6'h23, 6'h23, 6'h2B, 6'h2B, 6'h2B, 6'h00};
      for (int i = 0; i < 6; i++) begin
         drive(op[i], 1'b1);
         total++;
         if (bus.state !== st[i][3:0]) begin
            bad++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, bus.state, st[i]);
         end
         total++;
         if (bus.RegWrite !== (st[i] == 4) || bus.MemtoReg !== (st[i] == 4)) begin
            bad++; $display("FAIL lw_wb cyc=%0d RegWrite=%b MemtoReg=%b", i, bus.RegWrite, bus.MemtoReg);
         end
         if (st[i] == 3) begin
            total++;
            if (bus.MemRead !== 1'b1 || bus.IorD !== 1'b1) begin
               bad++; $display("FAIL lw_memrd MemRead=%b IorD=%b exp 1/1", bus.MemRead, bus.IorD);
            end
         end
         if (i == 0) begin
            total++;
            if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin
               bad++; $display("FAIL fetch_ready IRWrite=%b PCWrite=%b exp 1/1", bus.IRWrite, bus.PCWrite);
            end
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_sw;
      int st[8];
      logic mr[8];
      int mw_cnt;
      st = '{0, 1, 2, 5, 5, 5, 5, 0};
      mr = '{1, 1, 1, 0, 0, 0, 1, 1};
      mw_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(6'h2B, mr[i]);
         if (bus.MemWrite === 1'b1) mw_cnt++;
         total++;
         if (bus.state !== st[i][3:0] || bus.MemWrite !== (st[i] == 5)) begin
            bad++; $display("FAIL sw_cycle cyc=%0d state=%0d MemWrite=%b exp state=%0d", i, bus.state,
                            bus.MemWrite, st[i]);
         end
         total++;
         if (bus.RegWrite !== 1'b0 || (bus.MemRead & bus.MemWrite) !== 1'b0) begin
            bad++; $display("FAIL sw_excl cyc=%0d RegWrite=%b MemRead=%b MemWrite=%b", i, bus.RegWrite,
                            bus.MemRead, bus.MemWrite);
         end
         if (i < 7) @(negedge clk);
      end
      total++;
      if (mw_cnt != 4) begin
         bad++; $display("FAIL sw_hold_len got=%0d exp=4", mw_cnt);
      end
   endtask

   task automatic test_beq;
      int st[4];
      st = '{0, 1, 8, 0};
      for (int i = 0; i < 4; i++) begin
         drive(6'h04, 1'b1);
         total++;
         if (bus.state !== st[i][3:0]) begin
            bad++; $display("FAIL beq_state cyc=%0d got=%0d exp=%0d", i, bus.state, st[i]);
         end
         if (st[i] == 1) begin
            total++;
            if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} !== 5'b0_11_00) begin
               bad++; $display("FAIL beq_decode got=%b exp=01100", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp});
            end
         end
         if (st[i] == 8) begin
            total++;
            if ({bus.PCWriteCond, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCWrite}
                !== 9'b1_01_01_1_00_0) begin
               bad++; $display("FAIL beq_branch got=%b exp=101011000",
                               {bus.PCWriteCond, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.PCWrite});
            end
         end
         if (i < 3) @(negedge clk);
      end
   endtask

   task automatic test_jump;
      int st[6];
      logic mr[6];
      st = '{0, 0, 0, 1, 11, 0};
      mr = '{0, 0, 1, 1, 1, 1};
      for (int i = 0; i < 6; i++) begin
         drive(6'h02, mr[i]);
         total++;
         if (bus.state !== st[i][3:0]) begin
            bad++; $display("FAIL j_state cyc=%0d got=%0d exp=%0d", i, bus.state, st[i]);
         end
         if (i < 2) begin
            total++;
            if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0 || bus.MemRead !== 1'b1) begin
               bad++; $display("FAIL fetch_stall cyc=%0d IRWrite=%b PCWrite=%b MemRead=%b", i,
                               bus.IRWrite, bus.PCWrite, bus.MemRead);
            end
         end
         if (st[i] == 11) begin
            total++;
            if (bus.PCWrite !== 1'b1 || bus.PCSource !== 2'b10 || bus.PCWriteCond !== 1'b0) begin
               bad++; $display("FAIL j_jump PCWrite=%b PCSource=%b PCWriteCond=%b exp 1/10/0",
                               bus.PCWrite, bus.PCSource, bus.PCWriteCond);
            end
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_illegal;
      int st[3];
      st = '{0, 1, 0};
      for (int i = 0; i < 3; i++) begin
         drive(6'h3F, i == 2 ? 1'b0 : 1'b1);
         total++;
         if (bus.state !== st[i][3:0] || bus.illegalOp !== (i == 1)) begin
            bad++; $display("FAIL illegal cyc=%0d state=%0d illegalOp=%b exp state=%0d", i, bus.state,
                            bus.illegalOp, st[i]);
         end
         if (i < 2) @(negedge clk);
      end
   endtask

   task automatic test_rtype_addi;
      int st_r[5];
      int st_a[5];
      st_r = '{0, 1, 6, 7, 0};
      st_a = '{0, 1, 9, 10, 0};
      for (int i = 0; i < 5; i++) begin
         drive(6'h00, 1'b1);
         total++;
         if (bus.state !== st_r[i][3:0]) begin
            bad++; $display("FAIL rtype_state cyc=%0d got=%0d exp=%0d", i, bus.state, st_r[i]);
         end
         if (st_r[i] == 6) begin
            total++;
            if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite} !== 6'b1_00_10_0) begin
               bad++; $display("FAIL rtype_exec got=%b exp=100100", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite});
            end
         end
         if (st_r[i] == 7) begin
            total++;
            if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b110) begin
               bad++; $display("FAIL rtype_wb got=%b exp=110", {bus.RegWrite, bus.RegDst, bus.MemtoReg});
            end
         end
         if (i < 4) @(negedge clk);
      end
      for (int i = 0; i < 5; i++) begin
         drive(6'h08, 1'b1);
         total++;
         if (bus.state !== st_a[i][3:0]) begin
            bad++; $display("FAIL addi_state cyc=%0d got=%0d exp=%0d", i, bus.state, st_a[i]);
         end
         if (st_a[i] == 9) begin
            total++;
            if ({bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} !== 5'b1_10_00) begin
               bad++; $display("FAIL addi_exec got=%b exp=11000", {bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp});
            end
         end
         if (st_a[i] == 10) begin
            total++;
            if ({bus.RegWrite, bus.RegDst, bus.MemtoReg} !== 3'b100) begin
               bad++; $display("FAIL addi_wb got=%b exp=100", {bus.RegWrite, bus.RegDst, bus.MemtoReg});
            end
         end
         if (i < 4) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      int st[5];
      logic mr[5];
      st = '{0, 1, 2, 5, 5};
      mr = '{1, 1, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
         drive(6'h2B, mr[i]);
         total++;
         if (bus.state !== st[i][3:0]) begin
            bad++; $display("FAIL mid_state cyc=%0d got=%0d exp=%0d", i, bus.state, st[i]);
         end
         if (i < 4) @(negedge clk);
      end
      reset = 1'b1;
      #1;
      total++;
      if (outs() !== 21'd0) begin
         bad++; $display("FAIL mid_reset_outs got=%h exp=0", outs());
      end
      @(negedge clk);
      reset = 1'b0;
      drive(6'h00, 1'b0);
      total++;
      if (bus.state !== 4'd0 || bus.MemRead !== 1'b1 || bus.MemWrite !== 1'b0) begin
         bad++; $display("FAIL mid_release state=%0d MemRead=%b MemWrite=%b exp 0/1/0", bus.state,
                         bus.MemRead, bus.MemWrite);
      end
   endtask

   initial begin
      bus.opcode   = 6'h00;
      bus.memReady = 1'b0;
      test_reset();
      test_lw();
      test_sw();
      test_beq();
      test_jump();
      test_illegal();
      test_rtype_addi();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
